top_knight_rider: RTL and testbench
===================================

# top_knight_rider

Eight-LED "Knight Rider" scanner. A single lit LED bounces back and forth across the LED bank, moving one position per enabled step. It is the top-level of the LED-scanner task: it drives the board LEDs directly from a system clock, with an enable input gating motion.

## Interface
- `WIDTH`, default 8: number of LEDs. Legal values are 2 or more.
- `TICK_DIV`, default 1: enabled clock cycles per LED step. 1 means the LED moves on every enabled clock edge. Legal values are 1 or more.
- `clk`  input  1: system clock; all state changes on the rising edge.
- `arst`  input  1: reset, asynchronous and active-high. Forces the reset state immediately, independent of `clk`.
- `en`  input  1: motion enable, sampled on the `clk` rising edge.
- `leds`  output  WIDTH: one-hot LED drive. Bit 0 is the rightmost LED (LSB).

## Operation
- State consists of three items:
  - position index `pos`, in the range 0..WIDTH-1;
  - direction flag `up` (1 = moving toward the MSB);
  - prescaler counter (0..TICK_DIV-1).
- `leds` = 1 << `pos`, decoded from registered state. Exactly one bit is high at all times outside reset; there is no blank or all-off state.
- A step occurs on a rising edge when `en`=1 and the prescaler is at TICK_DIV-1. With TICK_DIV=1, every edge with `en`=1 is a step.
- Prescaler behaviour:
  - increments on each edge with `en`=1;
  - wraps to 0 on a step;
  - holds its value when `en`=0.
- Step rules, evaluated in this order:
  - `up`=1 and `pos`<WIDTH-1: `pos`+1.
  - `up`=1 and `pos`=WIDTH-1: `pos`=WIDTH-2, `up`=0. The turn and the first move happen in the same step; the MSB is never held for two steps.
  - `up`=0 and `pos`>0: `pos`-1.
  - `up`=0 and `pos`=0: `pos`=1, `up`=1.
- Resulting sequence for WIDTH=8: 0,1,…,7,6,…,0,1,… Period is 2·(WIDTH-1) steps = 14.
- `en`=0: `pos`, `up` and the prescaler all hold; `leds` stays steady.
- Illegal `pos` (≥WIDTH, only reachable for non-power-of-2 WIDTH): the next edge forces `pos`=0, `up`=1, regardless of `en`.

## Timing
- Reset values while `arst`=1:
  - `pos`=0, `up`=1, prescaler=0;
  - `leds`=0000_0001 for WIDTH=8, i.e. bit 0 only.
- `arst` has priority over `en`. Asserting it mid-sweep returns to LSB/up asynchronously, within the same cycle.
- After `arst` deasserts with `en`=1 and TICK_DIV=1:
  - `leds` is still 0000_0001 until the next rising edge;
  - the first edge gives 0000_0010.
- Latency: `leds` changes in the same edge that registers the step. There is no extra output pipeline stage.
- `en` asserted before an edge takes effect at that edge. `en` deasserted before an edge freezes the state at that edge.

## Structure
- Shared package `knightrider_pkg` holds:
  - default constants `KR_WIDTH_DEF`=8 and `KR_TICK_DIV_DEF`=1;
  - helper function `kr_idx_w(width)`, equal to $clog2(width), used to size `pos`.
- Sub-module `kr_tick_gen`: parameterised prescaler with inputs `clk`, `arst`, `en` and a one-cycle `tick` output. When TICK_DIV=1, `tick`=`en`.
- The top holds the bounce FSM (`pos`/`up` registers) and the one-hot decoder.

## Test plan
- Reset and initial state: `arst`=1, `en`=0, then release and set `en`=1 → `leds`=0000_0001 before the next edge; the first edge gives 0000_0010.
- Full bounce, TICK_DIV=1:
  - ascending: 0000_0010,0000_0100,…,1000_0000 on consecutive edges;
  - descending: 0100_0000,…,0000_0001;
  - the edge after that gives 0000_0010.
- Hold: drop `en` while `leds`=0001_0000 for 5 edges → value unchanged. Re-enable → next edge gives the correct neighbour in the prior direction.
- Mid-run reset: pulse `arst` between edges while `leds`=0100_0000 during descent → immediately 0000_0001. The next enabled edge gives 0000_0010 (direction is up).
- Prescaler: TICK_DIV=3 → `leds` advances once every 3 enabled edges. Gaps in `en` stretch the interval without losing prescaler count.
- One-hot invariant: a random `en` pattern over 1000 cycles gives `leds` with exactly one bit set every cycle, and successive distinct values are adjacent positions.

Source files
------------

// File: rtl/knightrider_pkg.sv
// Shared constants, types and helpers for the Knight Rider LED scanner.
package knightrider_pkg;

    localparam int KR_WIDTH_DEF    = 8;
    localparam int KR_TICK_DIV_DEF = 1;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } kr_dir_t;

    function automatic int kr_idx_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/kr_tick_gen.sv
// Prescaler: emits a one-cycle tick on every TICK_DIV-th enabled clock edge.
module kr_tick_gen
    import knightrider_pkg::*;
#(
    parameter int TICK_DIV = KR_TICK_DIV_DEF
) (
    input  logic clk,
    input  logic arst,
    input  logic en,
    output logic tick
);

    // One bit minimum keeps TICK_DIV=1 uniform: the count never leaves zero.
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/top_knight_rider.sv
// Knight Rider scanner: single lit LED bouncing between LSB and MSB.
module top_knight_rider
    import knightrider_pkg::*;
#(
    parameter int WIDTH    = KR_WIDTH_DEF,
    parameter int TICK_DIV = KR_TICK_DIV_DEF
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    output logic [WIDTH-1:0] leds
);

    localparam int IW = kr_idx_w(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    logic          tick;
    logic [IW-1:0] pos, pos_nxt;
    kr_dir_t       dir, dir_nxt;

    kr_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .arst (arst),
        .en   (en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pos <= '0;
            dir <= DIR_UP;
        end else begin
            pos <= pos_nxt;
            dir <= dir_nxt;
        end
    end

    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        // Out-of-range index recovers unconditionally, even with motion disabled.
        if (pos > LAST) begin
            pos_nxt = '0;
            dir_nxt = DIR_UP;
        end else if (tick) begin
            case (dir)
                DIR_UP: begin
                    if (pos == LAST) begin
                        pos_nxt = LAST - 1'b1;
                        dir_nxt = DIR_DN;
                    end else begin
                        pos_nxt = pos + 1'b1;
                    end
                end
                default: begin
                    if (pos == '0) begin
                        pos_nxt = IW'(1);
                        dir_nxt = DIR_UP;
                    end else begin
                        pos_nxt = pos - 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            leds[i] = (pos == IW'(i));
        end
    end

endmodule

// File: tb/tb_top_knight_rider.sv
// Self-checking bench: vector table, scoreboard queues and a bounce model.
module tb_top_knight_rider;

    logic       clk;
    logic       arst, arst3;
    logic       en, en3;
    logic [7:0] leds, leds3;

    top_knight_rider dut (
        .clk  (clk),
        .arst (arst),
        .en   (en),
        .leds (leds)
    );

    top_knight_rider #(.WIDTH(8), .TICK_DIV(3)) dut3 (
        .clk  (clk),
        .arst (arst3),
        .en   (en3),
        .leds (leds3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         en;
        logic [7:0] exp;
    } vec_t;

    vec_t       tab [27];
    logic [7:0] q1[$];
    logic [7:0] q3[$];
    int         errors = 0;
    int         checks = 0;

    // Reference state for both instances.
    int m_pos, m3_pos, m3_cnt;
    bit m_up, m3_up;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bounce(inout int p, inout bit u);
        if (u) begin
            if (p < 7) p++;
            else begin p = 6; u = 0; end
        end else begin
            if (p > 0) p--;
            else begin p = 1; u = 1; end
        end
    endtask

    // Drive one cycle; expected values enter the queues at drive time and are
    // popped once the edge has produced the DUT result.
    task automatic cycle(input bit e, input bit e3, input bit use_tab, input logic [7:0] tab_exp);
        logic [7:0] x1, x3;
        en  = e;
        en3 = e3;
        if (e) bounce(m_pos, m_up);
        if (e3 && !arst3) begin
            if (m3_cnt == 2) begin m3_cnt = 0; bounce(m3_pos, m3_up); end
            else m3_cnt++;
        end
        q1.push_back(use_tab ? tab_exp : 8'(1 << m_pos));
        q3.push_back(arst3 ? 8'h01 : 8'(1 << m3_pos));
        @(posedge clk);
        #1;
        x1 = q1.pop_front();
        x3 = q3.pop_front();
        chk(use_tab ? "table" : "model", leds, x1);
        if (use_tab) chk("table_vs_model", leds, 8'(1 << m_pos));
        chk("presc_model", leds3, x3);
    endtask

    initial begin
        logic [7:0] prev;
        tab = '{
            '{1, 8'h02}, '{1, 8'h04}, '{1, 8'h08}, '{1, 8'h10}, '{1, 8'h20},
            '{1, 8'h40}, '{1, 8'h80}, '{1, 8'h40}, '{1, 8'h20}, '{1, 8'h10},
            '{1, 8'h08}, '{1, 8'h04}, '{1, 8'h02}, '{1, 8'h01}, '{1, 8'h02},
            '{1, 8'h04}, '{1, 8'h08}, '{1, 8'h10},
            '{0, 8'h10}, '{0, 8'h10}, '{0, 8'h10}, '{0, 8'h10}, '{0, 8'h10},
            '{1, 8'h20}, '{1, 8'h40}, '{1, 8'h80}, '{1, 8'h40}
        };

        arst = 1'b1; arst3 = 1'b1; en = 1'b0; en3 = 1'b0;
        m_pos = 0; m_up = 1; m3_pos = 0; m3_up = 1; m3_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_leds", leds, 8'h01);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_priority", leds, 8'h01);
        en = 1'b0;
        arst = 1'b0;
        #1;
        en = 1'b1;
        #1;
        chk("pre_first_edge", leds, 8'h01);

        for (int i = 0; i < 27; i++) cycle(tab[i].en, 1'b0, 1'b1, tab[i].exp);

        // Asynchronous reset while descending through 0100_0000.
        #1;
        arst = 1'b1;
        #1;
        chk("async_reset", leds, 8'h01);
        m_pos = 0; m_up = 1;
        #1;
        arst = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        chk("post_reset_up", leds, 8'h02);

        // Prescaler with enable gaps.
        arst3 = 1'b0;
        m3_pos = 0; m3_up = 1; m3_cnt = 0;
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("presc_1", leds3, 8'h01);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("presc_2", leds3, 8'h01);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("presc_3", leds3, 8'h02);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("presc_gap_hold", leds3, 8'h02);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("presc_gap_step", leds3, 8'h04);

        // Random enables: model tracking, one-hot and adjacency.
        prev = leds;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 8'h00);
            checks++;
            if ($countones(leds) != 1) begin
                errors++;
                $display("FAIL onehot: got %b expected one bit set", leds);
            end
            if (leds != prev) begin
                checks++;
                if (leds != (prev << 1) && leds != (prev >> 1)) begin
                    errors++;
                    $display("FAIL adjacent: got %b expected neighbour of %b", leds, prev);
                end
                prev = leds;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
